// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder: one message bit in, one 2-bit coded symbol out,
// with optional zero-tail termination and trailing all-zero pad symbols per frame.
module conv_encoder #(
  parameter int unsigned    K         = 7,
  parameter logic [K-1:0]   G0        = 7'o171,
  parameter logic [K-1:0]   G1        = 7'o133,
  parameter int unsigned    FRAME_LEN = 512,
  parameter bit             TAIL_EN   = 1'b1,
  parameter int unsigned    PAD_LEN   = 32
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       d_in_valid,
  output logic       d_in_ready,
  input  logic       d_in,
  output logic       d_out_valid,
  input  logic       d_out_ready,
  output logic [1:0] d_out,
  output logic       d_out_last,
  output logic       busy
);

  localparam int unsigned BIT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned TAIL_W = (K > 2) ? $clog2(K) : 1;
  localparam int unsigned PAD_W  = (PAD_LEN > 1) ? $clog2(PAD_LEN) : 1;
  localparam bit          HAS_PAD = (PAD_LEN > 0);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_TAIL = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [K-2:0]        sr, sr_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [TAIL_W-1:0]   tail_cnt, tail_cnt_nxt;
  logic [PAD_W-1:0]    pad_cnt, pad_cnt_nxt;
  logic [1:0]          d_out_nxt;
  logic                d_out_valid_nxt;
  logic                d_out_last_nxt;

  logic                adv;
  logic                accept;
  logic                enc_bit;
  logic [K-1:0]        full;
  logic [1:0]          parity;
  logic                last_bit;
  logic                tail_done;
  logic                pad_done;

  // Output register may load whenever it is empty or being drained this cycle.
  assign adv        = !d_out_valid || d_out_ready;
  assign d_in_ready = (state == ST_DATA) && adv;
  assign accept     = d_in_valid && d_in_ready;
  assign busy       = (state != ST_DATA);

  // Newest bit sits at full[K-1]; tail cycles shift zeros through the register.
  assign enc_bit = (state == ST_DATA) ? d_in : 1'b0;
  assign full    = {enc_bit, sr};
  assign parity  = {^(full & G1), ^(full & G0)};

  assign last_bit  = (bit_cnt == BIT_W'(FRAME_LEN - 1));
  assign tail_done = (tail_cnt == TAIL_W'(K - 2));
  assign pad_done  = (pad_cnt == PAD_W'(PAD_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= ST_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA: begin
        if (accept && last_bit) begin
          if (TAIL_EN)      state_nxt = ST_TAIL;
          else if (HAS_PAD) state_nxt = ST_PAD;
          else              state_nxt = ST_DATA;
        end
      end
      ST_TAIL: begin
        if (adv && tail_done) state_nxt = HAS_PAD ? ST_PAD : ST_DATA;
      end
      ST_PAD: begin
        if (adv && pad_done) state_nxt = ST_DATA;
      end
      default: state_nxt = ST_DATA;
    endcase
  end

  // Datapath / output next values; everything holds unless the output stage advances.
  always_comb begin
    sr_nxt          = sr;
    bit_cnt_nxt     = bit_cnt;
    tail_cnt_nxt    = tail_cnt;
    pad_cnt_nxt     = pad_cnt;
    d_out_nxt       = d_out;
    d_out_valid_nxt = d_out_valid;
    d_out_last_nxt  = d_out_last;
    case (state)
      ST_DATA: begin
        if (accept) begin
          d_out_nxt       = parity;
          d_out_valid_nxt = 1'b1;
          if (last_bit) begin
            bit_cnt_nxt    = '0;
            d_out_last_nxt = !TAIL_EN && !HAS_PAD;
            // Without a tail the register is cleared so the next frame starts in state 0.
            sr_nxt         = TAIL_EN ? full[K-1:1] : '0;
          end else begin
            bit_cnt_nxt    = bit_cnt + BIT_W'(1);
            d_out_last_nxt = 1'b0;
            sr_nxt         = full[K-1:1];
          end
        end else if (adv) begin
          d_out_valid_nxt = 1'b0;
          d_out_last_nxt  = 1'b0;
        end
      end
      ST_TAIL: begin
        if (adv) begin
          d_out_nxt       = parity;
          d_out_valid_nxt = 1'b1;
          if (tail_done) begin
            tail_cnt_nxt   = '0;
            sr_nxt         = '0;
            d_out_last_nxt = !HAS_PAD;
          end else begin
            tail_cnt_nxt   = tail_cnt + TAIL_W'(1);
            sr_nxt         = full[K-1:1];
            d_out_last_nxt = 1'b0;
          end
        end
      end
      ST_PAD: begin
        if (adv) begin
          d_out_nxt       = 2'b00;
          d_out_valid_nxt = 1'b1;
          if (pad_done) begin
            pad_cnt_nxt    = '0;
            d_out_last_nxt = 1'b1;
          end else begin
            pad_cnt_nxt    = pad_cnt + PAD_W'(1);
            d_out_last_nxt = 1'b0;
          end
        end
      end
      default: begin
        sr_nxt          = '0;
        d_out_valid_nxt = 1'b0;
        d_out_last_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (RST) begin
      sr          <= '0;
      bit_cnt     <= '0;
      tail_cnt    <= '0;
      pad_cnt     <= '0;
      d_out       <= 2'b00;
      d_out_valid <= 1'b0;
      d_out_last  <= 1'b0;
    end else begin
      sr          <= sr_nxt;
      bit_cnt     <= bit_cnt_nxt;
      tail_cnt    <= tail_cnt_nxt;
      pad_cnt     <= pad_cnt_nxt;
      d_out       <= d_out_nxt;
      d_out_valid <= d_out_valid_nxt;
      d_out_last  <= d_out_last_nxt;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder: directed frames push expected symbols,
// independent monitors pop and compare on every output handshake.
module tb_conv_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance 0: K=7 defaults, FRAME_LEN=8, tail on, PAD_LEN=2
  logic       in_valid0, in_ready0, in_bit0;
  logic       out_valid0, out_ready0, last0, busy0;
  logic [1:0] out0;

  // Instance 1: FRAME_LEN=1, no tail, no pad
  logic       in_valid1, in_ready1, in_bit1;
  logic       out_valid1, out_ready1, last1, busy1;
  logic [1:0] out1;

  conv_encoder #(.FRAME_LEN(8), .TAIL_EN(1'b1), .PAD_LEN(2)) u_dut0 (
    .clk(clk), .RST(rst),
    .d_in_valid(in_valid0), .d_in_ready(in_ready0), .d_in(in_bit0),
    .d_out_valid(out_valid0), .d_out_ready(out_ready0), .d_out(out0),
    .d_out_last(last0), .busy(busy0)
  );

  conv_encoder #(.FRAME_LEN(1), .TAIL_EN(1'b0), .PAD_LEN(0)) u_dut1 (
    .clk(clk), .RST(rst),
    .d_in_valid(in_valid1), .d_in_ready(in_ready1), .d_in(in_bit1),
    .d_out_valid(out_valid1), .d_out_ready(out_ready1), .d_out(out1),
    .d_out_last(last1), .busy(busy1)
  );

  typedef struct packed {
    logic       busy;
    logic       last;
    logic [1:0] sym;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   n_seen0 = 0;
  logic bp_en = 1'b0;
  int   bp_cnt = 0;
  logic busy1_seen = 1'b0;

  // Hand-derived symbol streams: 8 data, 6 tail, 2 pad
  logic [1:0] t_imp [16] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00,
                             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] t_end [16] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11,
                             2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
  logic [1:0] t_two [16] = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11,
                             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name, input int cycles);
    checks++;
    errors++;
    $display("FAIL %s: no progress after %0d cycles (t=%0t)", name, cycles, $time);
  endtask

  task automatic push_frame0(input logic [1:0] s [16]);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.sym  = s[i];
      e.last = (i == 15);
      e.busy = (i >= 7) && (i < 15);
      q0.push_back(e);
    end
  endtask

  task automatic send_bit0(input logic b);
    int   n;
    logic acc;
    in_bit0   = b;
    in_valid0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) timeout("send_bit0", n);
    in_valid0 = 1'b0;
  endtask

  task automatic send_bit1(input logic b);
    int   n;
    logic acc;
    in_bit1   = b;
    in_valid1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) timeout("send_bit1", n);
    in_valid1 = 1'b0;
  endtask

  // Sends 8 bits LSB first; gap_at >= 0 inserts a 3-cycle bubble after that many bits
  task automatic send_frame0(input logic [7:0] bits, input int gap_at);
    for (int i = 0; i < 8; i++) begin
      send_bit0(bits[i]);
      if (i + 1 == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          @(posedge clk);
          #1;
          check("bubble_valid_low", int'(out_valid0), 0);
        end
      end
    end
  endtask

  task automatic drain0(input string name);
    int n;
    n = 0;
    while (q0.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q0.size() != 0) timeout(name, n);
    @(posedge clk);
    #1;
    check({name, "_idle_valid"}, int'(out_valid0), 0);
    check({name, "_idle_busy"}, int'(busy0), 0);
  endtask

  // Output-ready driver: 1-on/2-off while back-pressure is enabled
  initial begin
    out_ready0 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready0 = bp_en ? (bp_cnt % 3 == 0) : 1'b1;
      bp_cnt++;
    end
  end

  // Monitor for instance 0
  initial begin
    logic       prev_stall;
    logic [1:0] prev_sym;
    logic       prev_last;
    exp_t       e;
    prev_stall = 1'b0;
    prev_sym   = 2'b00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", int'(out_valid0), 1);
          check("stall_hold_sym", int'(out0), int'(prev_sym));
          check("stall_hold_last", int'(last0), int'(prev_last));
        end
        if (out_valid0 && !out_ready0) check("stall_in_ready", int'(in_ready0), 0);
        if (out_valid0 && out_ready0) begin
          if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sym0_extra: got symbol %b, required none (t=%0t)", out0, $time);
          end else begin
            e = q0.pop_front();
            check("sym0", int'(out0), int'(e.sym));
            check("last0", int'(last0), int'(e.last));
            check("busy0", int'(busy0), int'(e.busy));
          end
          n_seen0++;
        end
        prev_stall = out_valid0 && !out_ready0;
        prev_sym   = out0;
        prev_last  = last0;
      end
    end
  end

  // Monitor for instance 1
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy1) busy1_seen = 1'b1;
        if (out_valid1 && out_ready1) begin
          if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sym1_extra: got symbol %b, required none (t=%0t)", out1, $time);
          end else begin
            e = q1.pop_front();
            check("sym1", int'(out1), int'(e.sym));
            check("last1", int'(last1), int'(e.last));
            check("busy1", int'(busy1), int'(e.busy));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   n;
    exp_t e;
    rst       = 1'b1;
    in_valid0 = 1'b0;
    in_bit0   = 1'b0;
    in_valid1 = 1'b0;
    in_bit1   = 1'b0;
    out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid0", int'(out_valid0), 0);
    check("rst_dout0", int'(out0), 0);
    check("rst_last0", int'(last0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_in_ready0", int'(in_ready0), 1);
    check("rst_valid1", int'(out_valid1), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Impulse frame, no back-pressure
    push_frame0(t_imp);
    send_frame0(8'b0000_0001, -1);
    drain0("impulse");

    // Final data bit set: tail carries the impulse response
    push_frame0(t_end);
    send_frame0(8'b1000_0000, -1);
    drain0("tail_resp");

    // Impulse under 1-on/2-off back-pressure
    bp_en = 1'b1;
    push_frame0(t_imp);
    send_frame0(8'b0000_0001, -1);
    drain0("backpressure");
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Two ones with a 3-cycle input bubble after the third bit
    push_frame0(t_two);
    send_frame0(8'b0000_0011, 3);
    drain0("bubble");

    // Reset while the third tail symbol is on the output
    push_frame0(t_imp);
    base = n_seen0;
    send_frame0(8'b0000_0001, -1);
    n = 0;
    while (n_seen0 < base + 10 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n_seen0 < base + 10) timeout("reset_wait", n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", int'(out_valid0), 0);
    check("midrst_dout", int'(out0), 0);
    check("midrst_last", int'(last0), 0);
    check("midrst_busy", int'(busy0), 0);
    check("midrst_in_ready", int'(in_ready0), 1);
    rst = 1'b0;
    q0.delete();
    @(posedge clk);
    #1;
    push_frame0(t_imp);
    send_frame0(8'b0000_0001, -1);
    drain0("post_reset");

    // Single-bit frames, no tail, no pad
    for (int i = 0; i < 4; i++) begin
      e.sym  = 2'b11;
      e.last = 1'b1;
      e.busy = 1'b0;
      q1.push_back(e);
    end
    for (int i = 0; i < 4; i++) send_bit1(1'b1);
    n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q1.size() != 0) timeout("edge_drain", n);
    @(posedge clk);
    #1;
    check("edge_idle_valid", int'(out_valid1), 0);
    check("edge_busy_never", int'(busy1_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
